mem_chan_responder: RTL and testbench

- Memory-side end of one engine channel; the top level instantiates one per engine channel (16).
- Read side: answers the engine's read-address stream (RAddr / r_en) by fetching 768-bit edge words from a memory port and returning them on RData / RDataV.
- Write side: accepts the engine's 512-bit result words (WData / WDataV), throttles the engine with w_en, and drains buffered words to a memory write port at sequential addresses.
- Includes a run/flush/idle controller so the top level can quiesce the channel.

---
 rtl/mem_chan_responder.sv | 152 +++++++++++++++
 tb/tb_mem_chan_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_chan_responder.sv
// Memory-side responder for one engine channel: dedupes and issues engine reads,
// returns read data in order, and buffers engine result words for sequential writes.
module mem_chan_responder #(
  parameter int FIFO_WIDTH = 768,
  parameter int WR_WIDTH   = 512,
  parameter int MAX_RD_OUT = 8,
  parameter int WBUF_DEPTH = 8,
  parameter int WBUF_SKID  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chan_en,
  input  logic [31:0]           wr_base,
  input  logic [31:0]           RAddr,
  output logic                  r_en,
  output logic [FIFO_WIDTH-1:0] RData,
  output logic                  RDataV,
  input  logic [WR_WIDTH-1:0]   WData,
  input  logic                  WDataV,
  output logic                  w_en,
  output logic                  mem_rd_req,
  output logic [31:0]           mem_rd_addr,
  input  logic                  mem_rd_gnt,
  input  logic [FIFO_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic                  mem_wr_req,
  output logic [31:0]           mem_wr_addr,
  output logic [WR_WIDTH-1:0]   mem_wr_data,
  input  logic                  mem_wr_gnt,
  output logic                  chan_idle,
  output logic                  wr_overflow
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_RD_OUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state, state_next;
  logic              run, start;
  logic [31:0]       last_addr;
  logic              last_valid;
  logic [OUT_W-1:0]  rd_out;
  logic              issue;

  logic [WR_WIDTH-1:0] wbuf [WBUF_DEPTH];
  logic [PTR_W-1:0]    wb_head, wb_tail;
  logic [CNT_W-1:0]    wb_count, count_next;
  logic [31:0]         wr_ptr;
  logic                full, push, pop;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (chan_en) state_next = RUN;
      RUN:     if (!chan_en) state_next = FLUSH;
      FLUSH:   if (rd_out == '0 && !mem_rd_req && wb_count == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    chan_idle = (state == IDLE);
    run       = (state == RUN);
    start     = (state == IDLE) && chan_en;
  end

  // A stalled engine keeps RAddr constant; only a new address triggers a fetch.
  assign r_en  = run && (!mem_rd_req || mem_rd_gnt) && (rd_out < OUT_W'(MAX_RD_OUT));
  assign issue = r_en && (!last_valid || RAddr != last_addr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
      last_addr   <= '0;
      last_valid  <= 1'b0;
      rd_out      <= '0;
    end else begin
      if (issue) begin
        mem_rd_req  <= 1'b1;
        mem_rd_addr <= RAddr;
        last_addr   <= RAddr;
        last_valid  <= 1'b1;
      end else begin
        if (mem_rd_gnt) mem_rd_req <= 1'b0;
        if (start)      last_valid <= 1'b0;
      end
      // Late returns after a reset must not drive the count below zero.
      if (issue && !mem_rd_valid)
        rd_out <= rd_out + 1'b1;
      else if (!issue && mem_rd_valid && rd_out != '0)
        rd_out <= rd_out - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      RDataV <= 1'b0;
      RData  <= '0;
    end else begin
      RDataV <= mem_rd_valid;
      if (mem_rd_valid) RData <= mem_rd_data;
    end
  end

  assign full        = (wb_count == CNT_W'(WBUF_DEPTH));
  assign mem_wr_req  = (wb_count != '0);
  assign pop         = mem_wr_req && mem_wr_gnt;
  assign push        = WDataV && (!full || pop);
  assign mem_wr_addr = wr_ptr;
  assign mem_wr_data = mem_wr_req ? wbuf[wb_head] : '0;

  always_comb begin
    count_next = wb_count;
    if (push && !pop)      count_next = wb_count + 1'b1;
    else if (pop && !push) count_next = wb_count - 1'b1;
  end

  // NOTE: the storage array is deliberately not reset; pointers and count guard every read.
  always_ff @(posedge clk) begin
    if (push) wbuf[wb_tail] <= WData;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_head     <= '0;
      wb_tail     <= '0;
      wb_count    <= '0;
      wr_ptr      <= '0;
      wr_overflow <= 1'b0;
      w_en        <= 1'b0;
    end else begin
      if (push) wb_tail <= wb_tail + 1'b1;
      if (pop)  wb_head <= wb_head + 1'b1;
      wb_count <= count_next;
      if (start)    wr_ptr <= wr_base;
      else if (pop) wr_ptr <= wr_ptr + 32'd1;
      if (WDataV && !push) wr_overflow <= 1'b1;
      // Registered throttle leaves WBUF_SKID entries for words already in flight.
      w_en <= (state_next == RUN) && (count_next <= CNT_W'(WBUF_DEPTH - WBUF_SKID));
    end
  end

endmodule

// File: tb/tb_mem_chan_responder.sv
// Directed bench for mem_chan_responder: queue-based behavioural model compared every
// cycle, plus literal expectations for read streams, dedupe, caps, throttle, flush and reset.
module tb_mem_chan_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         chan_en = 1'b0;
  logic [31:0]  wr_base = 32'h100;
  logic [31:0]  RAddr = '0;
  logic         r_en;
  logic [767:0] RData;
  logic         RDataV;
  logic [511:0] WData = '0;
  logic         WDataV = 1'b0;
  logic         w_en;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_gnt = 1'b0;
  logic [767:0] mem_rd_data = '0;
  logic         mem_rd_valid = 1'b0;
  logic         mem_wr_req;
  logic [31:0]  mem_wr_addr;
  logic [511:0] mem_wr_data;
  logic         mem_wr_gnt = 1'b0;
  logic         chan_idle;
  logic         wr_overflow;

  mem_chan_responder dut (
    .clk(clk), .rst(rst), .chan_en(chan_en), .wr_base(wr_base),
    .RAddr(RAddr), .r_en(r_en), .RData(RData), .RDataV(RDataV),
    .WData(WData), .WDataV(WDataV), .w_en(w_en),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_gnt(mem_wr_gnt), .chan_idle(chan_idle), .wr_overflow(wr_overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_state = 0;  // 0 idle, 1 run, 2 flush
  int           m_rd_out = 0;
  logic [31:0]  m_last_addr = '0;
  bit           m_last_valid = 0;
  bit           m_req = 0;
  logic [31:0]  m_req_addr = '0;
  bit           m_rdv = 0;
  logic [767:0] m_rdata = '0;
  logic [511:0] m_wq[$];
  logic [31:0]  m_wr_ptr = '0;
  bit           m_ovf = 0;
  bit           m_wen = 0;

  function automatic bit model_ren();
    return (m_state == 1) && (!m_req || mem_rd_gnt) && (m_rd_out < 8);
  endfunction

  task automatic model_compare();
    check("r_en",        r_en,        model_ren());
    check("mem_rd_req",  mem_rd_req,  m_req);
    check("mem_rd_addr", mem_rd_addr, m_req_addr);
    check("RDataV",      RDataV,      m_rdv);
    check("RData",       RData,       m_rdata);
    check("w_en",        w_en,        m_wen);
    check("mem_wr_req",  mem_wr_req,  m_wq.size() != 0);
    check("mem_wr_addr", mem_wr_addr, m_wr_ptr);
    check("mem_wr_data", mem_wr_data, (m_wq.size() != 0) ? m_wq[0] : 512'd0);
    check("chan_idle",   chan_idle,   m_state == 0);
    check("wr_overflow", wr_overflow, m_ovf);
  endtask

  task automatic model_update();
    bit issue, pop, full;
    int nxt;
    if (!rst) begin
      m_state = 0; m_rd_out = 0; m_last_addr = '0; m_last_valid = 0;
      m_req = 0; m_req_addr = '0; m_rdv = 0; m_rdata = '0;
      m_wq.delete(); m_wr_ptr = '0; m_ovf = 0; m_wen = 0;
      return;
    end
    issue = model_ren() && (!m_last_valid || RAddr != m_last_addr);
    pop   = (m_wq.size() != 0) && mem_wr_gnt;
    full  = (m_wq.size() == 8);
    nxt   = m_state;
    case (m_state)
      0: if (chan_en) nxt = 1;
      1: if (!chan_en) nxt = 2;
      default: if (m_rd_out == 0 && !m_req && m_wq.size() == 0) nxt = 0;
    endcase
    if (issue) begin
      m_req = 1; m_req_addr = RAddr; m_last_addr = RAddr; m_last_valid = 1;
    end else if (mem_rd_gnt) m_req = 0;
    m_rd_out = m_rd_out + int'(issue) - int'(mem_rd_valid);
    if (m_rd_out < 0) m_rd_out = 0;
    m_rdv = mem_rd_valid;
    if (mem_rd_valid) m_rdata = mem_rd_data;
    if (pop) begin
      void'(m_wq.pop_front());
      m_wr_ptr = m_wr_ptr + 32'd1;
    end
    if (WDataV) begin
      if (!full || pop) m_wq.push_back(WData);
      else m_ovf = 1;
    end
    if (m_state == 0 && nxt == 1) begin
      m_wr_ptr = wr_base;
      m_last_valid = 0;
    end
    m_state = nxt;
    m_wen = (nxt == 1) && (m_wq.size() <= 6);
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_compare();
      @(posedge clk);
      model_update();
    end
  end

  // ---------------- driver / memory agent ----------------
  int          cyc = 0;
  bit          raddr_auto = 0;
  logic [31:0] raddr_limit = '0;
  int          ret_credit = -1;  // -1 = unlimited returns
  logic [31:0] ret_q[$];
  int          ret_due[$];
  logic [31:0] rd_addrs[$];
  logic [31:0] rdata_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          drv_out = 0;
  int          drv_out_max = 0;

  task automatic tick();
    bit adv;
    @(negedge clk);
    if (mem_rd_req && mem_rd_gnt) begin
      rd_addrs.push_back(mem_rd_addr);
      ret_q.push_back(mem_rd_addr);
      ret_due.push_back(cyc + 3);
      drv_out++;
    end
    if (mem_rd_valid) drv_out--;
    if (drv_out > drv_out_max) drv_out_max = drv_out;
    if (RDataV) rdata_log.push_back(RData[31:0]);
    if (mem_wr_req && mem_wr_gnt) begin
      wr_addr_log.push_back(mem_wr_addr);
      wr_data_log.push_back(mem_wr_data[31:0]);
    end
    adv = raddr_auto && r_en && (RAddr < raddr_limit);
    @(posedge clk);
    #1;
    cyc++;
    if (adv) RAddr = RAddr + 32'd1;
    mem_rd_valid = 1'b0;
    if (ret_q.size() != 0 && ret_due[0] <= cyc && ret_credit != 0) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 768'(ret_q.pop_front());
      void'(ret_due.pop_front());
      if (ret_credit > 0) ret_credit--;
    end
  endtask

  task automatic clear_logs();
    rd_addrs.delete(); rdata_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    #1;
    check("rst_chan_idle", chan_idle, 1'b1);
    check("rst_r_en", r_en, 1'b0);
    check("rst_w_en", w_en, 1'b0);
    check("rst_mem_rd_req", mem_rd_req, 1'b0);
    check("rst_mem_wr_req", mem_wr_req, 1'b0);

    // Stream 0..9
    rst = 1'b1; chan_en = 1'b1; mem_rd_gnt = 1'b1; RAddr = 0;
    raddr_auto = 1; raddr_limit = 9;
    repeat (22) tick();
    check("stream_rd_count", rd_addrs.size(), 10);
    check("stream_ret_count", rdata_log.size(), 10);
    for (int i = 0; i < 10 && i < rd_addrs.size(); i++) check("stream_rd_addr", rd_addrs[i], i);
    for (int i = 0; i < 10 && i < rdata_log.size(); i++) check("stream_rdata", rdata_log[i], i);

    // Stall / dedupe
    clear_logs(); raddr_auto = 0; drv_out = 0; drv_out_max = 0;
    RAddr = 5; repeat (6) tick();
    RAddr = 6; repeat (8) tick();
    check("dedupe_count", rd_addrs.size(), 2);
    if (rd_addrs.size() == 2) begin
      check("dedupe_first", rd_addrs[0], 5);
      check("dedupe_second", rd_addrs[1], 6);
    end
    check("dedupe_out_le2", drv_out_max <= 2, 1'b1);

    // Outstanding cap
    clear_logs(); ret_credit = 0; RAddr = 100; raddr_auto = 1; raddr_limit = 1000;
    repeat (14) tick();
    #1;
    check("cap_count", rd_addrs.size(), 8);
    if (rd_addrs.size() == 8) check("cap_last", rd_addrs[7], 107);
    check("cap_r_en", r_en, 1'b0);
    ret_credit = 1;
    repeat (5) tick();
    check("cap_reopen_count", rd_addrs.size(), 9);
    if (rd_addrs.size() == 9) check("cap_reopen_addr", rd_addrs[8], 108);
    mem_rd_gnt = 1'b0; ret_credit = 1;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("hold_req", mem_rd_req, 1'b1);
      check("hold_addr", mem_rd_addr, 109);
      check("hold_r_en", r_en, 1'b0);
    end
    mem_rd_gnt = 1'b1; raddr_auto = 0; ret_credit = -1;
    repeat (20) tick();

    // Write throttle (wr_base 0x100 sampled at first enable)
    clear_logs(); mem_wr_gnt = 1'b0;
    for (int i = 0; i < 9; i++) begin
      WDataV = 1'b1; WData = 512'(32'hA0 + i);
      tick();
      #1;
      check("thr_w_en", w_en, (i + 1) <= 6);
      check("thr_ovf", wr_overflow, i == 8);
    end
    WDataV = 1'b0; mem_wr_gnt = 1'b1;
    repeat (10) tick();
    check("thr_wr_count", wr_addr_log.size(), 8);
    for (int i = 0; i < 8 && i < wr_addr_log.size(); i++) begin
      check("thr_wr_addr", wr_addr_log[i], 32'h100 + i);
      check("thr_wr_data", wr_data_log[i], 32'hA0 + i);
    end

    // Flush with 3 reads outstanding and 4 writes buffered
    clear_logs(); mem_wr_gnt = 1'b0; ret_credit = 0;
    RAddr = 200; raddr_auto = 1; raddr_limit = 202;
    for (int i = 0; i < 6; i++) begin
      WDataV = (i < 4); WData = 512'(32'hB0 + i);
      tick();
    end
    WDataV = 1'b0;
    chan_en = 1'b0; mem_wr_gnt = 1'b1; ret_credit = -1; raddr_auto = 0;
    tick();
    #1;
    check("flush_not_idle", chan_idle, 1'b0);
    check("flush_r_en", r_en, 1'b0);
    check("flush_w_en", w_en, 1'b0);
    repeat (12) tick();
    #1;
    check("flush_idle", chan_idle, 1'b1);
    check("flush_ret_count", rdata_log.size(), 3);
    for (int i = 0; i < 3 && i < rdata_log.size(); i++) check("flush_rdata", rdata_log[i], 200 + i);
    check("flush_wr_count", wr_addr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
      check("flush_wr_addr", wr_addr_log[i], 32'h108 + i);
      check("flush_wr_data", wr_data_log[i], 32'hB0 + i);
    end

    // Re-enable with new base
    clear_logs(); wr_base = 32'h200; chan_en = 1'b1; RAddr = 0;
    repeat (4) tick();
    check("reen_rd_count", rd_addrs.size(), 1);
    if (rd_addrs.size() == 1) check("reen_rd_addr", rd_addrs[0], 0);
    WDataV = 1'b1; WData = 512'(32'hC0);
    tick();
    WDataV = 1'b0;
    repeat (3) tick();
    check("reen_wr_count", wr_addr_log.size(), 1);
    if (wr_addr_log.size() == 1) begin
      check("reen_wr_addr", wr_addr_log[0], 32'h200);
      check("reen_wr_data", wr_data_log[0], 32'hC0);
    end

    // Reset mid-run
    mem_wr_gnt = 1'b0; RAddr = 300; raddr_auto = 1; raddr_limit = 1000;
    for (int i = 0; i < 10; i++) begin
      WDataV = 1'b1; WData = 512'(32'hD0 + i);
      tick();
    end
    #1;
    check("pre_rst_ovf", wr_overflow, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1; WDataV = 1'b0; raddr_auto = 0;
    #1;
    check("mid_rst_rd_req", mem_rd_req, 1'b0);
    check("mid_rst_wr_req", mem_wr_req, 1'b0);
    check("mid_rst_w_en", w_en, 1'b0);
    check("mid_rst_r_en", r_en, 1'b0);
    check("mid_rst_idle", chan_idle, 1'b1);
    check("mid_rst_ovf", wr_overflow, 1'b0);
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
